qspi_flash_target: RTL and testbench

- Synthesizable, single-clock QSPI flash target. Successor to the behavioural flash model.
- Oversamples qspi_sclk and qspi_cs_n on the system clock and decodes SPI mode-0 commands.
- Adds 1-1-2, 1-1-4 and 1-4-4 reads, quad page program, WEL enforcement, WIP timing and page wrap.
- Backs onto an external synchronous memory port plus an erase handshake. Used as the on-chip or FPGA flash stand-in behind the controller.

---
 rtl/qspi_target_pkg.sv | 37 +++
 rtl/qspi_edge_sync.sv | 42 ++++
 rtl/qspi_flash_target.sv | 251 +++++++++++++++++++++++++
 tb/tb_qspi_flash_target.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_target_pkg.sv
// Shared opcodes, FSM states and lane-mode encoding for the QSPI flash target.
// No logic of its own; imported by the target top.
package qspi_target_pkg;

    localparam logic [7:0] OP_RDID   = 8'h9F;
    localparam logic [7:0] OP_RDSR   = 8'h05;
    localparam logic [7:0] OP_WREN   = 8'h06;
    localparam logic [7:0] OP_WRDI   = 8'h04;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_FREAD  = 8'h0B;
    localparam logic [7:0] OP_DREAD  = 8'h3B;
    localparam logic [7:0] OP_QREAD  = 8'h6B;
    localparam logic [7:0] OP_QIORD  = 8'hEB;
    localparam logic [7:0] OP_PP     = 8'h02;
    localparam logic [7:0] OP_QPP    = 8'h32;
    localparam logic [7:0] OP_SE     = 8'h20;

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, SR_OUT, ID_OUT, IGNORE
    } state_t;

    typedef enum logic [1:0] {LANE1, LANE2, LANE4} lane_t;

    function automatic lane_t lane_of(input logic [7:0] op);
        case (op)
            OP_DREAD:           return LANE2;
            OP_QREAD, OP_QIORD: return LANE4;
            default:            return LANE1;
        endcase
    endfunction

    function automatic logic is_read(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_FREAD) || (op == OP_DREAD) ||
               (op == OP_QREAD) || (op == OP_QIORD);
    endfunction

endpackage

// File: rtl/qspi_edge_sync.sv
// Two-flop synchronizers for sclk/cs_n/io plus sclk rise/fall and cs_n rise pulses.
// Latency: 2 clk to sync outputs, edge pulses one clk wide.
// Backpressure: none; free-running sampler.
module qspi_edge_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       qspi_sclk,
    input  logic       qspi_cs_n,
    input  logic [3:0] io_di,
    output logic       sclk_rise,
    output logic       sclk_fall,
    output logic       cs_n_sync,
    output logic       cs_rise,
    output logic [3:0] io_sync
);
    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [3:0] io_q1;
    logic [3:0] io_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            cs_q   <= '0;
            io_q1  <= '0;
            io_q2  <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], qspi_sclk};
            cs_q   <= {cs_q[1:0], qspi_cs_n};
            io_q1  <= io_di;
            io_q2  <= io_q1;
        end
    end

    // io_q2 is aligned with sclk_q[1], so it holds the data present at the edge.
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_n_sync = cs_q[1];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign io_sync   = io_q2;

endmodule

// File: rtl/qspi_flash_target.sv
// QSPI flash target: decodes mode-0 commands, drives a sync memory port and erase handshake.
// Latency: read byte fetched on address completion / byte start, data 1 clk after mem_rd_en.
// Backpressure: none; clk must be >= 8x qspi_sclk so prefetch completes before the next fall.
module qspi_flash_target
    import qspi_target_pkg::*;
#(
    parameter int          ADDR_BITS    = 24,
    parameter int          DUMMY_CYCLES = 8,
    parameter int          PAGE_SIZE    = 256,
    parameter int          PROG_CYCLES  = 64,
    parameter logic [23:0] JEDEC_ID     = 24'hC22017
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 qspi_sclk,
    input  logic                 qspi_cs_n,
    input  logic [3:0]           io_di,
    output logic [3:0]           io_do,
    output logic [3:0]           io_oe,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    output logic                 erase_req,
    output logic [ADDR_BITS-1:0] erase_addr,
    input  logic                 erase_ack,
    output logic                 wip
);
    localparam int         PAGE_BITS  = $clog2(PAGE_SIZE);
    localparam int         PC_W       = $clog2(PROG_CYCLES + 1);
    localparam logic [7:0] ADDR_LAST1 = 8'(ADDR_BITS - 1);
    localparam logic [7:0] ADDR_LAST4 = 8'(ADDR_BITS / 4 - 1);
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    logic       rise, fall, cs_n_s, cs_rise;
    logic [3:0] io_s;

    qspi_edge_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .qspi_sclk (qspi_sclk),
        .qspi_cs_n (qspi_cs_n),
        .io_di     (io_di),
        .sclk_rise (rise),
        .sclk_fall (fall),
        .cs_n_sync (cs_n_s),
        .cs_rise   (cs_rise),
        .io_sync   (io_s)
    );

    state_t               state, state_nxt;
    lane_t                lane;
    logic [7:0]           opcode;
    logic [6:0]           shreg;
    logic [7:0]           cnt;
    logic [ADDR_BITS-1:0] addr;
    logic                 quad_addr;
    logic [7:0]           out_sh;
    logic [2:0]           out_cnt;
    logic [1:0]           id_idx;
    logic [7:0]           rd_buf;
    logic                 rd_pend;
    logic                 wel, wip_q, wrote, erase_armed;
    logic [PC_W-1:0]      prog_cnt;

    logic [7:0]           cmd_byte, wr_byte;
    logic [ADDR_BITS-1:0] addr_full;
    logic                 addr_last, wr_last, need_dummy;

    assign cmd_byte   = {shreg, io_s[0]};
    assign wr_byte    = (opcode == OP_QPP) ? {shreg[3:0], io_s} : {shreg, io_s[0]};
    assign addr_full  = quad_addr ? {addr[ADDR_BITS-5:0], io_s} : {addr[ADDR_BITS-2:0], io_s[0]};
    assign addr_last  = (cnt == (quad_addr ? ADDR_LAST4 : ADDR_LAST1));
    assign wr_last    = (opcode == OP_QPP) ? cnt[0] : (cnt[2:0] == 3'd7);
    assign need_dummy = (opcode != OP_READ) && (DUMMY_CYCLES != 0);
    assign wip        = wip_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_n_s) begin
            state_nxt = IDLE;
        end else if (state == IDLE) begin
            state_nxt = CMD;
        end else if (rise) begin
            case (state)
                CMD: if (cnt == 8'd7) begin
                    if (wip_q && cmd_byte != OP_RDSR) state_nxt = IGNORE;
                    else case (cmd_byte)
                        OP_RDID: state_nxt = ID_OUT;
                        OP_RDSR: state_nxt = SR_OUT;
                        OP_READ, OP_FREAD, OP_DREAD, OP_QREAD, OP_QIORD,
                        OP_PP, OP_QPP, OP_SE: state_nxt = ADDR;
                        default: state_nxt = IGNORE;
                    endcase
                end
                ADDR: if (addr_last) begin
                    if (opcode == OP_PP || opcode == OP_QPP) state_nxt = wel ? WR_DATA : IGNORE;
                    else if (opcode == OP_SE)                state_nxt = IGNORE;
                    else                                     state_nxt = need_dummy ? DUMMY : RD_DATA;
                end
                DUMMY: if (cnt == DUMMY_LAST) state_nxt = RD_DATA;
                default: state_nxt = state;
            endcase
        end
    end

    // Output shifter: byte start loads the source byte, later falls shift out_sh.
    logic [7:0] src_byte, cur_byte, sh_nxt;
    logic [3:0] do_nxt, oe_pat;
    logic       out_last;

    always_comb begin
        src_byte = rd_buf;
        if (state == SR_OUT) src_byte = {6'b0, wel, wip_q};
        else if (state == ID_OUT) begin
            case (id_idx)
                2'd0:    src_byte = JEDEC_ID[23:16];
                2'd1:    src_byte = JEDEC_ID[15:8];
                default: src_byte = JEDEC_ID[7:0];
            endcase
        end
        cur_byte = (out_cnt == 3'd0) ? src_byte : out_sh;
        do_nxt   = {2'b00, cur_byte[7], 1'b0};
        sh_nxt   = {cur_byte[6:0], 1'b0};
        oe_pat   = 4'b0010;
        out_last = (out_cnt == 3'd7);
        case (lane)
            LANE2: begin
                do_nxt   = {2'b00, cur_byte[7:6]};
                sh_nxt   = {cur_byte[5:0], 2'b00};
                oe_pat   = 4'b0011;
                out_last = (out_cnt == 3'd3);
            end
            LANE4: begin
                do_nxt   = cur_byte[7:4];
                sh_nxt   = {cur_byte[3:0], 4'b0000};
                oe_pat   = 4'b1111;
                out_last = (out_cnt == 3'd1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane <= LANE1; opcode <= '0; shreg <= '0; cnt <= '0; addr <= '0;
            quad_addr <= 1'b0; out_sh <= '0; out_cnt <= '0; id_idx <= '0;
            rd_buf <= '0; rd_pend <= 1'b0; wel <= 1'b0; wip_q <= 1'b0;
            wrote <= 1'b0; erase_armed <= 1'b0; prog_cnt <= '0;
            io_do <= '0; io_oe <= '0; mem_rd_en <= 1'b0; mem_wr_en <= 1'b0;
            mem_addr <= '0; mem_wdata <= '0; erase_req <= 1'b0; erase_addr <= '0;
        end else begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            rd_pend   <= mem_rd_en;
            if (rd_pend) rd_buf <= mem_rdata;

            if (state_nxt != state)  cnt <= '0;
            else if (rise && !cs_n_s) cnt <= cnt + 8'd1;

            if (!cs_n_s && rise) begin
                case (state)
                    CMD: begin
                        shreg <= cmd_byte[6:0];
                        if (cnt == 8'd7) begin
                            opcode    <= cmd_byte;
                            lane      <= lane_of(cmd_byte);
                            quad_addr <= (cmd_byte == OP_QIORD);
                            out_cnt   <= '0;
                            id_idx    <= '0;
                            if (!wip_q && cmd_byte == OP_WREN) wel <= 1'b1;
                            if (!wip_q && cmd_byte == OP_WRDI) wel <= 1'b0;
                        end
                    end
                    ADDR: begin
                        addr <= addr_full;
                        if (addr_last && is_read(opcode)) begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= addr_full;
                            addr      <= addr_full + 1'b1;
                        end else if (addr_last && opcode == OP_SE && wel) begin
                            erase_armed <= 1'b1;
                            erase_addr  <= {addr_full[ADDR_BITS-1:12], 12'h000};
                        end
                    end
                    WR_DATA: begin
                        shreg <= wr_byte[6:0];
                        if (wr_last) begin
                            mem_wr_en <= 1'b1;
                            mem_wdata <= wr_byte;
                            mem_addr  <= addr;
                            addr      <= {addr[ADDR_BITS-1:PAGE_BITS], addr[PAGE_BITS-1:0] + 1'b1};
                            wrote     <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (!cs_n_s && fall && (state == RD_DATA || state == SR_OUT || state == ID_OUT)) begin
                io_oe   <= oe_pat;
                io_do   <= do_nxt;
                out_sh  <= sh_nxt;
                out_cnt <= out_last ? 3'd0 : out_cnt + 3'd1;
                if (out_cnt == 3'd0 && state == RD_DATA) begin
                    mem_rd_en <= 1'b1;
                    mem_addr  <= addr;
                    addr      <= addr + 1'b1;
                end
                if (out_cnt == 3'd0 && state == ID_OUT)
                    id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
            end

            if (cs_rise) begin
                io_oe       <= '0;
                io_do       <= '0;
                out_cnt     <= '0;
                wrote       <= 1'b0;
                erase_armed <= 1'b0;
                if (wrote) begin
                    wip_q    <= 1'b1;
                    prog_cnt <= PC_W'(PROG_CYCLES);
                end
                if (erase_armed) begin
                    erase_req <= 1'b1;
                    wip_q     <= 1'b1;
                end
            end else begin
                if (prog_cnt != '0) begin
                    prog_cnt <= prog_cnt - 1'b1;
                    if (prog_cnt == PC_W'(1)) begin
                        wip_q <= 1'b0;
                        wel   <= 1'b0;
                    end
                end
                if (erase_req && erase_ack) begin
                    erase_req <= 1'b0;
                    wip_q     <= 1'b0;
                    wel       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_qspi_flash_target.sv
// Directed bench for qspi_flash_target: RDID, quad reads, quad program with page wrap,
// WEL gating, WIP timing and the erase handshake, driven as an SPI mode-0 controller.
module tb_qspi_flash_target;

    logic        clk = 1'b0;
    logic        rst;
    logic        qspi_sclk, qspi_cs_n;
    logic [3:0]  io_di, io_do, io_oe;
    logic        mem_rd_en, mem_wr_en;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        erase_req, erase_ack, wip;
    logic [23:0] erase_addr;

    always #5 clk = ~clk;

    qspi_flash_target #(.PROG_CYCLES(400)) dut (
        .clk        (clk),
        .rst        (rst),
        .qspi_sclk  (qspi_sclk),
        .qspi_cs_n  (qspi_cs_n),
        .io_di      (io_di),
        .io_do      (io_do),
        .io_oe      (io_oe),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .erase_req  (erase_req),
        .erase_addr (erase_addr),
        .erase_ack  (erase_ack),
        .wip        (wip)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model with a few fixed bytes; everything else is a simple address hash.
    logic [23:0] rd_log[$];
    logic [31:0] wr_log[$];

    function automatic logic [7:0] rmem(input logic [23:0] a);
        case (a)
            24'h000100: return 8'hA5;
            24'h000101: return 8'h3C;
            24'h00FFFF: return 8'h5A;
            24'h010000: return 8'hC3;
            default:    return a[7:0] ^ 8'h96;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= rmem(mem_addr);
            rd_log.push_back(mem_addr);
        end
        if (mem_wr_en) wr_log.push_back({mem_addr, mem_wdata});
    end

    logic [3:0] last_oe;

    task automatic sck(input logic [3:0] din, output logic [3:0] dout);
        io_di = din;
        #50 qspi_sclk = 1'b1;
        dout    = io_do;
        last_oe = io_oe;
        #50 qspi_sclk = 1'b0;
    endtask

    task automatic x1(input logic [7:0] tx, output logic [7:0] rx);
        logic [3:0] d;
        for (int i = 7; i >= 0; i--) begin
            sck({3'b000, tx[i]}, d);
            rx[i] = d[1];
        end
    endtask

    task automatic x4(input logic [7:0] tx, output logic [7:0] rx);
        logic [3:0] d;
        sck(tx[7:4], d);
        rx[7:4] = d;
        sck(tx[3:0], d);
        rx[3:0] = d;
    endtask

    task automatic cs_lo();
        qspi_cs_n = 1'b0;
        #50;
    endtask

    task automatic cs_hi();
        #50 qspi_cs_n = 1'b1;
        #200;
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic [7:0] r;
        logic [7:0] b;
        b = a[23:16]; x1(b, r);
        b = a[15:8];  x1(b, r);
        b = a[7:0];   x1(b, r);
    endtask

    initial begin
        logic [7:0]  r0, r1;
        logic [3:0]  d;
        logic [31:0] acc;

        rst = 1'b1; qspi_sclk = 1'b0; qspi_cs_n = 1'b1; io_di = 4'h0; erase_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_ctl", 32'({io_do, io_oe, mem_rd_en, mem_wr_en, erase_req, wip}), 32'h0);
        check("rst_bus", 32'({mem_addr, mem_wdata}), 32'h0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_eaddr", 32'(erase_addr), 32'h0);

        // RDID: opcode then 32 clocks of ID bytes, wrapping back to byte 0
        cs_lo();
        x1(8'h9F, r0);
        check("rdid_oe_opcode", 32'(last_oe), 32'h0);
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            x1(8'h00, r0);
            acc = {acc[23:0], r0};
        end
        check("rdid_oe_data", 32'(last_oe), 32'h2);
        cs_hi();
        check("rdid_bytes", acc, 32'hC22017C2);
        check("rdid_oe_cs_hi", 32'(io_oe), 32'h0);

        // 0x6B quad-output read at 0x000100
        rd_log.delete();
        cs_lo();
        x1(8'h6B, r0);
        send_addr(24'h000100);
        repeat (8) sck(4'h0, d);
        x4(8'h00, r0);
        x4(8'h00, r1);
        check("qread_oe", 32'(last_oe), 32'hF);
        cs_hi();
        check("qread_b0", 32'(r0), 32'hA5);
        check("qread_b1", 32'(r1), 32'h3C);
        check("qread_a0", 32'(rd_log[0]), 32'h000100);
        check("qread_a1", 32'(rd_log[1]), 32'h000101);

        // 0xEB quad-io read across a 64KB boundary
        rd_log.delete();
        cs_lo();
        x1(8'hEB, r0);
        x4(8'h00, r0);
        x4(8'hFF, r0);
        x4(8'hFF, r0);
        repeat (8) sck(4'h0, d);
        x4(8'h00, r0);
        x4(8'h00, r1);
        cs_hi();
        check("qioread_b0", 32'(r0), 32'h5A);
        check("qioread_b1", 32'(r1), 32'hC3);
        check("qioread_a0", 32'(rd_log[0]), 32'h00FFFF);
        check("qioread_a1", 32'(rd_log[1]), 32'h010000);

        // quad program without WREN is dropped
        wr_log.delete();
        cs_lo();
        x1(8'h32, r0);
        send_addr(24'h0000FE);
        x4(8'h11, r0);
        cs_hi();
        check("nowel_writes", 32'(wr_log.size()), 32'd0);
        check("nowel_wip", 32'(wip), 32'd0);

        // WREN then quad program of 3 bytes wrapping inside the page
        cs_lo(); x1(8'h06, r0); cs_hi();
        cs_lo();
        x1(8'h32, r0);
        send_addr(24'h0000FE);
        x4(8'h11, r0);
        x4(8'h22, r0);
        x4(8'h33, r0);
        cs_hi();
        check("pp_count", 32'(wr_log.size()), 32'd3);
        check("pp_w0", wr_log[0], 32'h0000FE11);
        check("pp_w1", wr_log[1], 32'h0000FF22);
        check("pp_w2", wr_log[2], 32'h00000033);
        check("pp_wip_pin", 32'(wip), 32'd1);

        cs_lo();
        x1(8'h05, r0);
        x1(8'h00, r0);
        x1(8'h00, r1);
        cs_hi();
        check("rdsr_busy0", 32'(r0), 32'h03);
        check("rdsr_busy1", 32'(r1), 32'h03);

        repeat (450) @(posedge clk);
        #1;
        check("prog_wip_done", 32'(wip), 32'd0);
        cs_lo(); x1(8'h05, r0); x1(8'h00, r0); cs_hi();
        check("rdsr_idle", 32'(r0), 32'h00);

        // sector erase handshake; reads during WIP are ignored
        cs_lo(); x1(8'h06, r0); cs_hi();
        cs_lo();
        x1(8'h20, r0);
        send_addr(24'h012345);
        cs_hi();
        check("se_req", 32'(erase_req), 32'd1);
        check("se_addr", 32'(erase_addr), 32'h012000);
        check("se_wip", 32'(wip), 32'd1);

        rd_log.delete();
        cs_lo();
        x1(8'h03, r0);
        send_addr(24'h000100);
        x1(8'h00, r0);
        check("busy_read_oe", 32'(last_oe), 32'h0);
        cs_hi();
        check("busy_read_mem", 32'(rd_log.size()), 32'd0);

        @(posedge clk); #1 erase_ack = 1'b1;
        @(posedge clk); #1 erase_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("ack_req", 32'(erase_req), 32'd0);
        check("ack_wip", 32'(wip), 32'd0);
        cs_lo(); x1(8'h05, r0); x1(8'h00, r0); cs_hi();
        check("rdsr_after_erase", 32'(r0), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
